// File: rtl/svo_ldi_pack.sv
// rtl/svo_ldi_pack.sv - OpenLDI pixel packer: dual-link split, VESA/JEIDA mapping, underflow fill, lock status
// Optional PRBS7 training pattern generator is built when SVO_LDI_PRBS_EN is defined.
module svo_ldi_pack #(
    parameter int NUM_LINKS  = 1,
    parameter int LANES      = 4,
    parameter int CHK_FRAMES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mapping,
    input  logic                         train,
    input  logic                         in_axis_tvalid,
    output logic                         in_axis_tready,
    input  logic [23:0]                  in_axis_tdata,
    input  logic [3:0]                   in_axis_tuser,
    output logic                         out_valid,
    output logic [NUM_LINKS*LANES*7-1:0] out_lanes,
    output logic                         align_err,
    output logic [15:0]                  underflow_cnt,
    output logic                         locked
);
    localparam int LW = LANES * 7;
    localparam int OW = NUM_LINKS * LW;
    localparam int CW = $clog2(CHK_FRAMES + 1);

    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;

    phase_t          r_phase;
    logic            r_map;
    logic            r_hs;
    logic            r_vs;
    logic [LW-1:0]   r_held;
    logic [CW-1:0]   r_frames;

    logic            w_fs;
    logic            w_map;
    logic            w_hs;
    logic            w_vs;
    logic            w_de;
    logic            w_train;
    logic            w_err;
    logic            w_strobe;
    logic [23:0]     w_rgb;
    logic [27:0]     w_full;
    logic [LW-1:0]   w_word;
    logic [2*LW-1:0] w_cat;
    logic [OW-1:0]   w_data;
    logic [OW-1:0]   w_out;

    // Lane k sits at bits [k*7 +: 7]; each lane word is listed MSB (first transmitted) first.
    function automatic logic [27:0] pack_px(input logic [23:0] px, input logic de,
                                            input logic hs, input logic vs, input logic jeida);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = px[7:0];
        g = px[15:8];
        b = px[23:16];
        if (jeida)
            return {1'b0, b[1:0], g[1:0], r[1:0], de, vs, hs, b[7:4],
                    b[3:2], g[7:3], g[2], r[7:2]};
        else
            return {1'b0, b[7:6], g[7:6], r[7:6], de, vs, hs, b[5:2],
                    b[1:0], g[5:1], g[0], r[5:0]};
    endfunction

    assign in_axis_tready = ~reset;
    assign w_fs   = in_axis_tvalid & in_axis_tuser[0];
    assign w_map  = w_fs ? mapping : r_map;
    assign w_hs   = in_axis_tvalid ? in_axis_tuser[1] : r_hs;
    assign w_vs   = in_axis_tvalid ? in_axis_tuser[2] : r_vs;
    assign w_de   = in_axis_tvalid & ~in_axis_tuser[3];
    assign w_rgb  = in_axis_tvalid ? in_axis_tdata : 24'd0;
    assign w_full = pack_px(w_rgb, w_de, w_hs, w_vs, (LANES == 3) ? 1'b1 : w_map);
    assign w_word = w_full[LW-1:0];
    // Held even pixel goes on link 0 (low bits); single link just takes the current word.
    assign w_cat  = {w_word, r_held};
    assign w_data = w_cat[2*LW-1 -: OW];

    assign w_strobe = (NUM_LINKS == 1) || (r_phase == ODD && !w_fs);
    assign w_err    = (!in_axis_tvalid && !w_train) ||
                      (NUM_LINKS == 2 && r_phase == ODD && w_fs);

`ifdef SVO_LDI_PRBS_EN
    logic [6:0] r_lfsr;
    logic [6:0] w_prbs_word;
    logic [6:0] w_lfsr_next;

    function automatic logic [13:0] prbs7_step(input logic [6:0] state);
        logic [6:0] s;
        logic [6:0] w;
        s = state;
        w = '0;
        for (int i = 0; i < 7; i++) begin
            w[6-i] = s[6] ^ s[5];
            s      = {s[5:0], w[6-i]};
        end
        return {w, s};
    endfunction

    assign {w_prbs_word, w_lfsr_next} = prbs7_step(r_lfsr);
    assign w_train = train;
    assign w_out   = w_train ? {(NUM_LINKS*LANES){w_prbs_word}} : w_data;

    always_ff @(posedge clk) begin
        if (reset || !train)
            r_lfsr <= 7'h7F;
        else if (w_strobe)
            r_lfsr <= w_lfsr_next;
    end
`else
    logic w_unused_train;
    assign w_unused_train = train;
    assign w_train        = 1'b0;
    assign w_out          = w_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase       <= EVEN;
            r_map         <= 1'b0;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
            r_held        <= '0;
            r_frames      <= '0;
            out_valid     <= 1'b0;
            out_lanes     <= '0;
            align_err     <= 1'b0;
            underflow_cnt <= 16'd0;
            locked        <= 1'b0;
        end else begin
            r_map     <= w_map;
            r_hs      <= w_hs;
            r_vs      <= w_vs;
            out_valid <= w_strobe;
            align_err <= 1'b0;
            if (w_strobe)
                out_lanes <= w_out;
            if (r_phase == EVEN || w_fs)
                r_held <= w_word;
            // A frame start in ODD drops the held pixel and becomes the new even pixel.
            if (NUM_LINKS == 2) begin
                if (r_phase == EVEN)
                    r_phase <= ODD;
                else if (w_fs)
                    align_err <= 1'b1;
                else
                    r_phase <= EVEN;
            end
            if (!in_axis_tvalid && !w_train && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
            if (w_err || w_train) begin
                r_frames <= '0;
                locked   <= 1'b0;
            end else if (w_fs && r_frames != CW'(CHK_FRAMES)) begin
                r_frames <= r_frames + CW'(1);
                locked   <= ((r_frames + CW'(1)) == CW'(CHK_FRAMES));
            end
        end
    end
endmodule
